// File: rtl/harvos_dma_arbiter.sv
// Four-requester round-robin DMA arbiter in front of a single firewall master port.
// Tracks per-requester faults, aborts stalled accesses, and locks out repeat offenders.
module harvos_dma_arbiter #(
   parameter int TIMEOUT     = 255,
   parameter int LOCK_THRESH = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   m_req,
   input  logic [3:0]   m_we,
   input  logic [15:0]  m_be,
   input  logic [127:0] m_addr,
   input  logic [127:0] m_wdata,
   output logic [3:0]   m_done,
   output logic [3:0]   m_fault,
   output logic [31:0]  m_rdata,
   output logic         d_req,
   output logic         d_we,
   output logic [3:0]   d_be,
   output logic [31:0]  d_addr,
   output logic [31:0]  d_wdata,
   input  logic [31:0]  d_rdata,
   input  logic         d_done,
   input  logic         d_fault,
   input  logic [3:0]   clr,
   output logic [3:0]   locked,
   output logic [31:0]  fault_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_ABORT = 2'd3;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [4:0]  LOCK_LVL = 5'(LOCK_THRESH);

   logic [1:0]       state;
   logic [1:0]       gnt;
   logic [1:0]       last;
   logic             lat_we;
   logic [3:0]       lat_be;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;
   logic [15:0]      tmo_cnt;
   logic [3:0]       lock_q;
   logic [3:0][7:0]  fcnt;
   logic [3:0][3:0]  consec;

   logic [3:0]       eligible;
   logic             pick_valid;
   logic [1:0]       pick_idx;
   logic [1:0]       cand;
   logic             done_ok;
   logic             done_abort;
   logic             done_any;
   logic             done_fault;

   assign eligible = m_req & ~lock_q;

   // Scan starts one past the last grant, so the previous winner is considered last.
   always_comb begin
      // NOTE: every variable assigned here gets a default first, otherwise paths
      // that skip an assignment would infer a latch.
      pick_valid = 1'b0;
      pick_idx   = last;
      cand       = last;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!pick_valid && eligible[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // A d_done that lands on the final WAIT cycle is a normal completion, not an abort.
   assign done_ok    = (state == ST_WAIT) && d_done;
   assign done_abort = (state == ST_ABORT);
   assign done_any   = done_ok || done_abort;
   assign done_fault = done_abort || (done_ok && d_fault);

   assign m_done    = done_any   ? (4'b0001 << gnt) : 4'b0000;
   assign m_fault   = done_fault ? (4'b0001 << gnt) : 4'b0000;
   assign m_rdata   = (done_ok && !lat_we) ? d_rdata : 32'h0;
   assign d_req     = (state == ST_ISSUE);
   assign d_we      = lat_we;
   assign d_be      = lat_be;
   assign d_addr    = lat_addr;
   assign d_wdata   = lat_wdata;
   assign locked    = lock_q;
   assign fault_cnt = fcnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         gnt       <= 2'd0;
         last      <= 2'd3;
         lat_we    <= 1'b0;
         lat_be    <= 4'h0;
         lat_addr  <= 32'h0;
         lat_wdata <= 32'h0;
         tmo_cnt   <= 16'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt       <= pick_idx;
                  last      <= pick_idx;
                  lat_we    <= m_we[pick_idx];
                  lat_be    <= m_be[4*pick_idx +: 4];
                  lat_addr  <= m_addr[32*pick_idx +: 32];
                  lat_wdata <= m_wdata[32*pick_idx +: 32];
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tmo_cnt <= 16'h0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (d_done) begin
                  state <= ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= ST_ABORT;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            ST_ABORT: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Fault bookkeeping; a clear pulse overrides a same-cycle fault for that requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q <= 4'h0;
         fcnt   <= '0;
         consec <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (clr[i]) begin
               lock_q[i] <= 1'b0;
               fcnt[i]   <= 8'h0;
               consec[i] <= 4'h0;
            end else if (done_any && (gnt == 2'(i))) begin
               if (done_fault) begin
                  if (fcnt[i] != 8'hFF) fcnt[i] <= fcnt[i] + 8'd1;
                  if (consec[i] != 4'hF) consec[i] <= consec[i] + 4'd1;
                  if (({1'b0, consec[i]} + 5'd1) >= LOCK_LVL) lock_q[i] <= 1'b1;
               end else begin
                  consec[i] <= 4'h0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_harvos_dma_arbiter.sv
// Randomized bench for harvos_dma_arbiter: a transaction-level model predicts grant
// order, response routing, timeouts and the fault/lockout counters.
module tb_harvos_dma_arbiter;

   localparam int TO = 8;
   localparam int LT = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   m_req, m_we, clr;
   logic [15:0]  m_be;
   logic [127:0] m_addr, m_wdata;
   logic [3:0]   m_done, m_fault, locked;
   logic [31:0]  m_rdata, d_addr, d_wdata, d_rdata, fault_cnt;
   logic         d_req, d_we, d_done, d_fault;
   logic [3:0]   d_be;

   harvos_dma_arbiter #(.TIMEOUT(TO), .LOCK_THRESH(LT)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_be(m_be),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_done(m_done), .m_fault(m_fault),
      .m_rdata(m_rdata), .d_req(d_req), .d_we(d_we), .d_be(d_be),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .d_fault(d_fault), .clr(clr), .locked(locked), .fault_cnt(fault_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   int          last_g;
   bit          mlock [4];
   int          mfcnt [4];
   int          mcons [4];
   logic [31:0] f_addr  [4];
   logic [31:0] f_wdata [4];
   logic [3:0]  f_be    [4];
   logic        f_we    [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pack_fields();
      for (int i = 0; i < 4; i++) begin
         m_addr[32*i +: 32]  = f_addr[i];
         m_wdata[32*i +: 32] = f_wdata[i];
         m_be[4*i +: 4]      = f_be[i];
         m_we[i]             = f_we[i];
      end
   endtask

   task automatic random_fields();
      for (int i = 0; i < 4; i++) begin
         f_addr[i]  = $urandom;
         f_wdata[i] = $urandom;
         f_be[i]    = 4'($urandom);
         f_we[i]    = 1'($urandom);
      end
      pack_fields();
   endtask

   task automatic model_reset();
      last_g = 3;
      for (int i = 0; i < 4; i++) begin
         mlock[i] = 1'b0; mfcnt[i] = 0; mcons[i] = 0;
      end
   endtask

   task automatic model_clear(input logic [3:0] mask);
      for (int i = 0; i < 4; i++)
         if (mask[i]) begin
            mlock[i] = 1'b0; mfcnt[i] = 0; mcons[i] = 0;
         end
   endtask

   task automatic model_complete(input int g, input bit flt);
      if (flt) begin
         if (mfcnt[g] < 255) mfcnt[g]++;
         mcons[g]++;
         if (mcons[g] >= LT) mlock[g] = 1'b1;
      end else begin
         mcons[g] = 0;
      end
   endtask

   function automatic int model_pick(input logic [3:0] req);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (last_g + k) % 4;
         if (req[i] && !mlock[i]) return i;
      end
      return -1;
   endfunction

   task automatic check_status();
      logic [31:0] el, ef;
      el = 32'h0;
      ef = 32'h0;
      for (int i = 0; i < 4; i++) begin
         el[i]       = mlock[i];
         ef[8*i +: 8] = 8'(mfcnt[i]);
      end
      check("locked", 32'(locked), el);
      check("fault_cnt", fault_cnt, ef);
   endtask

   // Present req in an IDLE cycle and wait (bounded) for the issue cycle.
   task automatic wait_issue(input logic [3:0] req, input int g, output bit seen);
      int cyc;
      seen = 1'b0;
      cyc  = 0;
      for (int c = 0; c < 6 && !seen; c++) begin
         @(negedge clk);
         m_req = req; d_done = 1'b0; d_fault = 1'b0; clr = 4'h0;
         #1;
         if (c == 0) check_status();
         if (d_req) begin
            seen = 1'b1;
            cyc  = c;
         end
      end
      if (g < 0) begin
         check("no_grant", 32'(seen), 32'd0);
      end else begin
         check("grant_seen", 32'(seen), 32'd1);
         if (seen) begin
            check("issue_latency", 32'(cyc), 32'd1);
            check("d_addr", d_addr, f_addr[g]);
            check("d_wdata", d_wdata, f_wdata[g]);
            check("d_be", 32'(d_be), 32'(f_be[g]));
            check("d_we", 32'(d_we), 32'(f_we[g]));
            last_g = g;
         end
      end
   endtask

   // One transaction: d_done on WAIT cycle lat (lat > TO means the access times out).
   task automatic run_txn(input logic [3:0] req, input int lat, input bit flt,
                          input logic [31:0] rdat, input bit drop, input bit cl);
      int g;
      bit seen, fin;
      logic [3:0] oh;
      g = model_pick(req);
      wait_issue(req, g, seen);
      if (g < 0 || !seen) return;
      oh  = 4'(1 << g);
      fin = 1'b0;
      for (int k = 1; k <= TO + 1 && !fin; k++) begin
         @(negedge clk);
         if (drop) m_req = 4'h0;
         d_rdata = rdat;
         d_fault = flt;
         d_done  = (k == lat) || (k == TO + 1);
         if (k == TO + 1) d_fault = 1'b0;
         clr = 4'h0;
         if (cl && (k == lat || k == TO + 1)) clr = oh;
         #1;
         if (k == lat && lat <= TO) begin
            check("done", 32'(m_done), 32'(oh));
            check("fault", 32'(m_fault), flt ? 32'(oh) : 32'd0);
            check("rdata", m_rdata, f_we[g] ? 32'h0 : rdat);
            model_complete(g, flt);
            fin = 1'b1;
         end else if (k <= TO) begin
            check("wait_done", 32'(m_done), 32'd0);
            check("wait_fault", 32'(m_fault), 32'd0);
            check("wait_rdata", m_rdata, 32'h0);
         end else begin
            check("abort_done", 32'(m_done), 32'(oh));
            check("abort_fault", 32'(m_fault), 32'(oh));
            check("abort_rdata", m_rdata, 32'h0);
            model_complete(g, 1'b1);
            fin = 1'b1;
            @(negedge clk);
            m_req = 4'h0; d_done = 1'b1; clr = 4'h0;
            #1;
            check("late_done", 32'(m_done), 32'd0);
            check("late_dreq", 32'(d_req), 32'd0);
         end
         if (fin && cl) model_clear(oh);
      end
   endtask

   task automatic do_clr(input logic [3:0] mask);
      @(negedge clk);
      m_req = 4'h0; d_done = 1'b0; clr = mask;
      @(negedge clk);
      clr = 4'h0;
      model_clear(mask);
   endtask

   initial begin
      bit seen;
      int g;
      rst = 1'b1;
      m_req = 4'h0; clr = 4'h0; d_done = 1'b0; d_fault = 1'b0; d_rdata = 32'h0;
      random_fields();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_m_done", 32'(m_done), 32'd0);
      check("rst_m_fault", 32'(m_fault), 32'd0);
      check("rst_m_rdata", m_rdata, 32'h0);
      check("rst_d_req", 32'(d_req), 32'd0);
      check("rst_d_addr", d_addr, 32'h0);
      check("rst_d_wdata", d_wdata, 32'h0);
      check("rst_d_be_we", {27'h0, d_be, d_we}, 32'h0);
      check_status();
      @(negedge clk);
      rst = 1'b0;

      // All requesters active: strict rotation starting at 0.
      random_fields();
      for (int i = 0; i < 5; i++) run_txn(4'b1111, 2, 1'b0, $urandom, 1'b0, 1'b0);

      // Read by requester 2 returns downstream data.
      f_addr[2] = 32'h0000_4000;
      f_we[2]   = 1'b0;
      pack_fields();
      run_txn(4'b0100, 1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);

      // Timeout abort, then d_done coincident with the expiry cycle.
      run_txn(4'b0001, TO + 1, 1'b0, $urandom, 1'b0, 1'b0);
      run_txn(4'b1000, TO, 1'b1, $urandom, 1'b0, 1'b0);
      run_txn(4'b1000, TO, 1'b0, $urandom, 1'b1, 1'b0);

      // Lockout of requester 1 and release by clear.
      do_clr(4'b1111);
      random_fields();
      for (int i = 0; i < 3; i++) run_txn(4'b0010, 2, 1'b1, $urandom, 1'b0, 1'b0);
      run_txn(4'b0010, 2, 1'b0, $urandom, 1'b0, 1'b0);
      run_txn(4'b0011, 2, 1'b0, $urandom, 1'b0, 1'b0);
      do_clr(4'b0010);
      run_txn(4'b0010, 2, 1'b0, $urandom, 1'b0, 1'b0);

      // Reset mid-transaction: no completion, pointer back to requester 0.
      random_fields();
      f_we[1] = 1'b1;
      pack_fields();
      g = model_pick(4'b1111);
      wait_issue(4'b1111, g, seen);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("pre_rst_done", 32'(m_done), 32'd0);
      end
      @(negedge clk);
      rst = 1'b1; m_req = 4'h0;
      #1;
      check("mid_rst_done", 32'(m_done), 32'd0);
      check("mid_rst_dreq", 32'(d_req), 32'd0);
      check("mid_rst_addr", d_addr, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0; d_done = 1'b1; d_fault = 1'b1;
      #1;
      check("post_rst_done", 32'(m_done), 32'd0);
      check("post_rst_fault", 32'(m_fault), 32'd0);
      run_txn(4'b1111, 2, 1'b0, $urandom, 1'b0, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         random_fields();
         if ($urandom_range(0, 7) == 0) do_clr(4'($urandom));
         run_txn(4'($urandom), $urandom_range(1, TO + 2), ($urandom_range(0, 2) == 0),
                 $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
